// File: rtl/div_pkg.sv
// Shared types and constants for the divider writeback queue: result record,
// drain-window states and sticky error bit positions.
package div_pkg;

   localparam int DIV_LATENCY = 35;
   localparam int DIV_DEPTH   = 4;
   localparam int DIV_TAG_W   = 5;

   localparam int ERR_OVF    = 0;
   localparam int ERR_ORPHAN = 1;

   typedef struct packed {
      logic [DIV_TAG_W-1:0] rd;
      logic [31:0]          data;
      logic                 exc;
   } div_result_t;

   typedef enum logic {
      ST_DRAIN = 1'b0,
      ST_RUN   = 1'b1
   } drain_state_t;

   // A faulted divide never forwards the divider's garbage answer.
   function automatic div_result_t pack_result(input logic [DIV_TAG_W-1:0] rd,
                                               input logic [31:0]          answer,
                                               input logic                 exc);
      div_result_t r;
      r.rd   = rd;
      r.data = exc ? 32'd0 : answer;
      r.exc  = exc;
      return r;
   endfunction

endpackage

// File: rtl/div_writeback_queue_if.sv
// Bundle of the issue, divider-result and writeback signals around the queue.
// valid/ready: a transfer happens on a rising edge where both are high; the
// sender holds its payload stable while valid is high and ready is low.
interface div_writeback_queue_if #(
   parameter int TAG_W = 5
);
   logic             issue_valid;
   logic [TAG_W-1:0] issue_rd;
   logic             issue_ready;
   logic [31:0]      div_answer;
   logic             div_exception;
   logic             div_rdy;
   logic             wb_valid;
   logic             wb_ready;
   logic [TAG_W-1:0] wb_rd;
   logic [31:0]      wb_data;
   logic             wb_exception;
   logic [1:0]       err;

   modport master (
      output issue_valid, issue_rd, div_answer, div_exception, div_rdy, wb_ready,
      input  issue_ready, wb_valid, wb_rd, wb_data, wb_exception, err
   );

   modport slave (
      input  issue_valid, issue_rd, div_answer, div_exception, div_rdy, wb_ready,
      output issue_ready, wb_valid, wb_rd, wb_data, wb_exception, err
   );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage; head reads the oldest entry, so a
// pushed word becomes visible the cycle after the push edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset: entries are only read once count says they exist.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/div_writeback_queue.sv
// Tags divider results with their destination register in issue order and
// buffers them for the writeback arbiter, with credit-based flow control.
module div_writeback_queue
   import div_pkg::*;
#(
   parameter int LATENCY = DIV_LATENCY,
   parameter int DEPTH   = DIV_DEPTH,
   parameter int TAG_W   = DIV_TAG_W
) (
   input  logic                  clock,
   input  logic                  reset,
   div_writeback_queue_if.slave  bus,
   output drain_state_t          state
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int DW = $clog2(LATENCY + 1);
   localparam int RW = $bits(div_result_t);

   drain_state_t  state_next;
   logic [DW-1:0] drain_cnt;
   logic [DW-1:0] drain_cnt_next;
   logic          draining;

   logic [TAG_W-1:0] tag_head;
   logic [CW-1:0]    tag_count;
   logic             tag_empty;
   logic [CW-1:0]    res_count;
   logic             res_empty;
   logic [RW-1:0]    res_head_raw;
   logic [RW-1:0]    res_push_raw;
   div_result_t      res_head;
   div_result_t      res_in;

   logic [CW:0] used;
   logic        issue_ready;
   logic        issue_accept;
   logic        tag_pop;
   logic        orphan;
   logic        res_pop;
   logic [1:0]  err_q;

   // The divider keeps computing through our reset, so results that emerge
   // during the first LATENCY cycles belong to divides we no longer track.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_DRAIN;
         drain_cnt <= DW'(LATENCY);
      end else begin
         state     <= state_next;
         drain_cnt <= drain_cnt_next;
      end
   end

   always_comb begin
      state_next     = state;
      drain_cnt_next = drain_cnt;
      case (state)
         ST_DRAIN: begin
            if (drain_cnt <= DW'(1)) begin
               drain_cnt_next = '0;
               state_next     = ST_RUN;
            end else begin
               drain_cnt_next = drain_cnt - DW'(1);
            end
         end
         ST_RUN: begin
            drain_cnt_next = '0;
         end
         default: begin
            state_next     = ST_DRAIN;
            drain_cnt_next = DW'(LATENCY);
         end
      endcase
   end

   assign draining = (state == ST_DRAIN);

   // Credits span both FIFOs, so every tracked divide already owns a result slot.
   assign used         = {1'b0, tag_count} + {1'b0, res_count};
   assign issue_ready  = (used < (CW+1)'(DEPTH)) && !draining;
   assign issue_accept = bus.issue_valid && issue_ready;
   assign tag_pop      = bus.div_rdy && !draining && !tag_empty;
   assign orphan       = bus.div_rdy && !draining && tag_empty;
   assign res_pop      = bus.wb_valid && bus.wb_ready;

   sync_fifo #(
      .WIDTH (TAG_W),
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (issue_accept),
      .push_data (bus.issue_rd),
      .pop       (tag_pop),
      .head      (tag_head),
      .count     (tag_count),
      .empty     (tag_empty)
   );

   assign res_in       = pack_result(DIV_TAG_W'(tag_head), bus.div_answer, bus.div_exception);
   assign res_push_raw = res_in;

   sync_fifo #(
      .WIDTH (RW),
      .DEPTH (DEPTH)
   ) u_result_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (tag_pop),
      .push_data (res_push_raw),
      .pop       (res_pop),
      .head      (res_head_raw),
      .count     (res_count),
      .empty     (res_empty)
   );

   assign res_head = div_result_t'(res_head_raw);

   always_ff @(posedge clock) begin
      if (reset) begin
         err_q <= '0;
      end else begin
         if (bus.issue_valid && !issue_ready) err_q[ERR_OVF]    <= 1'b1;
         if (orphan)                          err_q[ERR_ORPHAN] <= 1'b1;
      end
   end

   assign bus.issue_ready  = issue_ready;
   assign bus.wb_valid     = !res_empty;
   assign bus.wb_rd        = res_empty ? '0 : TAG_W'(res_head.rd);
   assign bus.wb_data      = res_empty ? '0 : res_head.data;
   assign bus.wb_exception = res_empty ? 1'b0 : res_head.exc;
   assign bus.err          = err_q;

endmodule

// File: tb/tb_div_writeback_queue.sv
// Randomised and directed bench for div_writeback_queue with a modelled divider
// and an in-order scoreboard of expected writeback records.
module tb_div_writeback_queue;
   import div_pkg::*;

   localparam int LAT   = 35;
   localparam int DEPTH = 4;
   localparam int TW    = 5;
   localparam int W     = TW + 33;

   typedef struct {
      int          due;
      logic [31:0] ans;
      logic        exc;
   } div_ev_t;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   drain_state_t fsm_state;

   div_writeback_queue_if #(.TAG_W(TW)) bus ();

   div_writeback_queue #(
      .LATENCY (LAT),
      .DEPTH   (DEPTH),
      .TAG_W   (TW)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave),
      .state (fsm_state)
   );

   always #5 clock = ~clock;

   int checks    = 0;
   int errors    = 0;
   int cyc       = 0;
   int since_rst = 0;
   int pend      = 0;

   div_ev_t        div_q[$];
   logic [W-1:0]   exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Divider model: fixed latency, no stall, keeps running across our reset.
   always @(posedge clock) begin
      cyc++;
      since_rst = reset ? 0 : since_rst + 1;
      #1;
      if (div_q.size() > 0 && div_q[0].due == cyc) begin
         bus.div_rdy       = 1'b1;
         bus.div_answer    = div_q[0].ans;
         bus.div_exception = div_q[0].exc;
         void'(div_q.pop_front());
      end else begin
         bus.div_rdy       = 1'b0;
         bus.div_answer    = $urandom;
         bus.div_exception = 1'b0;
      end
   end

   // Monitor: credit availability every cycle, stability under back-pressure,
   // and in-order comparison of every accepted writeback.
   logic         stall_prev = 1'b0;
   logic [W-1:0] stall_val;
   logic [W-1:0] head;
   always @(negedge clock) begin
      if (reset) begin
         stall_prev = 1'b0;
      end else begin
         check("issue_ready", 64'(bus.issue_ready),
               64'((since_rst >= LAT) && ((exp_q.size() - pend) < DEPTH)));
         head = {bus.wb_rd, bus.wb_data, bus.wb_exception};
         if (stall_prev) begin
            check("wb_stall_valid", 64'(bus.wb_valid), 64'd1);
            check("wb_stall_stable", 64'(head), 64'(stall_val));
         end
         stall_prev = 1'b0;
         if (bus.wb_valid && bus.wb_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL wb_unexpected: got %0h expected no transfer (cycle %0d)", head, cyc);
            end else begin
               check("wb_result", 64'(head), 64'(exp_q.pop_front()));
            end
         end else if (bus.wb_valid) begin
            stall_prev = 1'b1;
            stall_val  = head;
         end
      end
   end

   task automatic start_issue(input logic [TW-1:0] rd, input logic [31:0] a, input logic [31:0] b);
      logic exc;
      exc             = (b == 32'd0);
      bus.issue_valid = 1'b1;
      bus.issue_rd    = rd;
      div_q.push_back('{cyc + LAT, exc ? $urandom : a / b, exc});
      exp_q.push_back({rd, exc ? 32'd0 : a / b, exc});
      pend = 1;
   endtask

   task automatic do_issue(input logic [TW-1:0] rd, input logic [31:0] a, input logic [31:0] b);
      start_issue(rd, a, b);
      @(posedge clock); #1;
      bus.issue_valid = 1'b0;
      pend = 0;
   endtask

   task automatic do_reset();
      reset           = 1'b1;
      bus.issue_valid = 1'b0;
      bus.wb_ready    = 1'b0;
      pend            = 0;
      exp_q.delete();
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!bus.issue_ready && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      if (!bus.issue_ready) begin
         checks++;
         errors++;
         $display("FAIL wait_ready: got timeout expected issue_ready");
      end
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!bus.wb_valid && n < 60) begin
         @(posedge clock); #1;
         n++;
      end
      if (!bus.wb_valid) begin
         checks++;
         errors++;
         $display("FAIL wait_valid: got timeout expected wb_valid");
      end
   endtask

   task automatic pop_one();
      bus.wb_ready = 1'b1;
      @(posedge clock); #1;
      bus.wb_ready = 1'b0;
   endtask

   task automatic wait_empty();
      int n;
      n = 0;
      bus.wb_ready = 1'b1;
      while ((exp_q.size() != 0 || bus.wb_valid) && n < 300) begin
         @(posedge clock); #1;
         n++;
      end
      bus.wb_ready = 1'b0;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d outstanding expected 0", exp_q.size());
      end
   endtask

   initial begin
      int c0;
      int t;
      logic [31:0] b;

      bus.issue_valid = 1'b0;
      bus.issue_rd    = '0;
      bus.wb_ready    = 1'b0;

      // Reset values and drain window length
      @(posedge clock); #1;
      c0 = cyc;
      do_reset();
      check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
      check("rst_wb_rd", 64'(bus.wb_rd), 64'd0);
      check("rst_wb_data", 64'(bus.wb_data), 64'd0);
      check("rst_wb_exc", 64'(bus.wb_exception), 64'd0);
      check("rst_err", 64'(bus.err), 64'd0);
      check("rst_issue_ready", 64'(bus.issue_ready), 64'd0);
      check("rst_state", 64'(fsm_state), 64'(ST_DRAIN));
      wait_ready();
      check("drain_len", 64'(cyc - c0), 64'(LAT + 1));

      // Basic: 100/7 to rd 7, end-to-end latency
      t = cyc;
      do_issue(5'd7, 32'd100, 32'd7);
      wait_valid();
      check("basic_latency", 64'(cyc - t), 64'(LAT + 1));
      check("basic_rd", 64'(bus.wb_rd), 64'd7);
      check("basic_data", 64'(bus.wb_data), 64'd14);
      check("basic_exc", 64'(bus.wb_exception), 64'd0);
      pop_one();
      check("basic_empty", 64'(bus.wb_valid), 64'd0);

      // Divide by zero
      do_issue(5'd3, $urandom, 32'd0);
      wait_valid();
      check("dz_rd", 64'(bus.wb_rd), 64'd3);
      check("dz_data", 64'(bus.wb_data), 64'd0);
      check("dz_exc", 64'(bus.wb_exception), 64'd1);
      pop_one();

      // Credit limit, overflow issue, in-order drain
      for (int i = 0; i < 4; i++) do_issue(5'(10 + i), $urandom, 32'($urandom_range(1, 500)));
      check("credit_full", 64'(bus.issue_ready), 64'd0);
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 5'd31;
      @(posedge clock); #1;
      bus.issue_valid = 1'b0;
      check("ovf_err", 64'(bus.err), 64'd1);
      repeat (40) begin @(posedge clock); #1; end
      check("credit_head_rd", 64'(bus.wb_rd), 64'd10);
      wait_empty();

      // Simultaneous tag push/pop and result push/pop with used held at 3
      do_reset();
      wait_ready();
      do_issue(5'd20, 32'd900, 32'd9);
      do_issue(5'd21, 32'd77, 32'd0);
      do_issue(5'd22, 32'd64, 32'd8);
      repeat (33) begin @(posedge clock); #1; end
      check("sim_head_valid", 64'(bus.wb_valid), 64'd1);
      bus.wb_ready = 1'b1;
      start_issue(5'd23, 32'd1000, 32'd3);
      @(posedge clock); #1;
      bus.issue_valid = 1'b0;
      pend = 0;
      bus.wb_ready = 1'b0;
      check("sim_ready_kept", 64'(bus.issue_ready), 64'd1);
      check("sim_next_rd", 64'(bus.wb_rd), 64'd21);
      repeat (40) begin @(posedge clock); #1; end
      wait_empty();

      // Reset with divides in flight; stale results must be ignored
      do_issue(5'd5, 32'd50, 32'd5);
      do_issue(5'd6, 32'd60, 32'd6);
      repeat (8) begin @(posedge clock); #1; end
      c0 = cyc;
      do_reset();
      wait_ready();
      check("midrst_ready_len", 64'(cyc - c0), 64'(LAT + 1));
      repeat (3) begin @(posedge clock); #1; end
      check("midrst_err", 64'(bus.err), 64'd0);
      check("midrst_wb_valid", 64'(bus.wb_valid), 64'd0);

      // Orphan result with no tag outstanding
      div_q.push_back('{cyc + 1, 32'hdead_beef, 1'b0});
      repeat (3) begin @(posedge clock); #1; end
      check("orphan_err", 64'(bus.err), 64'd2);
      check("orphan_wb_valid", 64'(bus.wb_valid), 64'd0);

      // Randomised traffic with random back-pressure
      do_reset();
      wait_ready();
      for (int i = 0; i < 800; i++) begin
         bus.wb_ready = 1'($urandom_range(0, 1));
         if (bus.issue_ready && $urandom_range(0, 2) != 0) begin
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
            start_issue(5'($urandom_range(0, 31)), $urandom, b);
         end else begin
            bus.issue_valid = 1'b0;
            pend = 0;
         end
         @(posedge clock); #1;
      end
      bus.issue_valid = 1'b0;
      pend = 0;
      repeat (40) begin @(posedge clock); #1; end
      wait_empty();
      check("rand_err", 64'(bus.err), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
